mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Sequences one fully-connected MLP layer built from n_pe PE instances sharing one broadcast input bus.
//  Per input vector: clears the PE accumulators, streams data_size FP16 samples onto the bus under a
//  valid/ready handshake, waits out the PE pipeline, snapshots every PE accumulator, then serialises
//  the n_pe results through an output valid/ready port. Sits between the input-vector FIFO and the next layer.
// PARAMETERS
//  tam        16  word width (IEEE-754 half precision)
//  data_size  4   samples per input vector = weights per PE
//  n_pe       4   PEs (neurons) driven by this sequencer
//  pe_lat     2   cycles from last pe_en beat to final acc_out valid at PE outputs (>=1)
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous reset, active-high
//  start      in   1            begin one vector; sampled only in IDLE
//  in_data    in   tam          input sample
//  in_valid   in   1            in_data valid
//  in_ready   out  1            sequencer accepts in_data this cycle
//  pe_rst     out  1            reset to all PEs (clears acc, weight index)
//  pe_bus     out  tam          broadcast bus_in to all PEs
//  pe_en      out  1            pe_bus holds a new sample this cycle (PE steps MAC + weight index)
//  pe_acc     in   n_pe*tam     concatenated PE acc_out; PE k at [k*tam +: tam]
//  out_data   out  tam          result word
//  out_idx    out  $clog2(n_pe) neuron index of out_data (width 1 if n_pe==1)
//  out_valid  out  1            out_data/out_idx valid
//  out_ready  in   1            downstream accepts result
//  busy       out  1            high in any state except IDLE
//  done       out  1            one-cycle pulse after last result accepted
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; pe_rst=1, pe_bus=0, pe_en=0, out_data=0, out_idx=0,
//   out_valid=0, busy=0, done=0, all counters 0; any in-flight vector is discarded.
//  All outputs registered except in_ready = (state==STREAM) && (cnt < data_size).
//  FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> SNAP -> OUTPUT -> IDLE.
//  IDLE: pe_rst=1; start=1 -> CLEAR. in_valid ignored.
//  CLEAR: one cycle, pe_rst=1, cnt=0 -> STREAM. pe_rst low from first STREAM cycle.
//  STREAM: handshake = in_valid & in_ready; on handshake pe_bus<=in_data, pe_en<=1 next cycle, cnt++;
//   no handshake -> pe_en<=0, pe_bus holds. On handshake with cnt==data_size-1 -> DRAIN (no bubble).
//  DRAIN: pe_en=0; counts pe_lat cycles, then -> SNAP.
//  SNAP: one cycle, pe_acc copied into internal n_pe x tam buffer; idx=0 -> OUTPUT.
//  OUTPUT: out_valid=1, out_data=buf[idx] (post-processed, see CONFIGURATION), out_idx=idx;
//   out_ready=0 -> data/idx stable; accept with idx<n_pe-1 -> idx++; accept at idx==n_pe-1 ->
//   out_valid=0, done=1 for one cycle, -> IDLE.
//  start outside IDLE ignored (no queueing). start and in_valid in same IDLE cycle: sample not accepted.
//  Minimum latency start->done with in_valid, out_ready held high: 1+data_size+pe_lat+1+n_pe cycles.
//  data_size==1: single STREAM beat. Arithmetic is not performed here; words pass through unmodified
//   apart from the optional activation. pe_rst stays high in IDLE so PEs never accumulate stray data.
// CONFIGURATION
//  MLP_SEQ_RELU_EN defined: out_data = buf[idx][tam-1] ? {tam{1'b0}} : buf[idx] (FP16 ReLU;
//   -0.0 maps to +0.0; NaN with sign set maps to 0).
//  Not defined: out_data = buf[idx] unchanged; timing identical in both builds.
// TESTING
//  1 rst mid-STREAM (after 2 beats) -> next cycle busy=0, pe_rst=1, in_ready=0, out_valid=0; new start runs clean.
//  2 weights {1.0,2.0,3.0,4.0} in every PE, bias 0, start + 4 beats of 0x3C00, out_ready=1 ->
//    out_data=0x4900 (10.0) for out_idx 0..3, done 12 cycles after start (n_pe=4, pe_lat=2).
//  3 in_valid toggling 1,0,1,0 -> pe_en high only on accepted beats, pe_bus holds in gaps, same 0x4900 results.
//  4 out_ready low 3 cycles at idx 1 -> out_data/out_idx stable, idx 2 follows release, done once.
//  5 acc forced 0xC900 (-10.0): RELU_EN -> 0x0000; without -> 0xC900. 0x8000 -> 0x0000 / 0x8000.
//  6 start pulsed during DRAIN and OUTPUT -> ignored; exactly one done; in_ready stays 0 outside STREAM.

Source files
------------

// File: rtl/mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// MlpLayerSequencer (module mlp_layer_sequencer)
//
// Sequences one fully-connected MLP layer made of n_pe PEs that share a
// single broadcast input bus. For each input vector the sequencer:
//   1. clears every PE accumulator,
//   2. streams data_size samples onto the bus under a valid/ready handshake,
//   3. waits out the PE pipeline latency,
//   4. snapshots all PE accumulators into a local buffer,
//   5. serialises the n_pe results through a valid/ready output port.
//
// Optional feature:
//   MLP_SEQ_RELU_EN  when defined, every result passes through an FP16 ReLU
//                    (any word with the sign bit set becomes +0.0). When not
//                    defined, results pass through unchanged. Timing is the
//                    same in both builds.
//
// Parameters:
//   tam        word width (FP16 = 16)
//   data_size  samples per input vector (= weights per PE)
//   n_pe       number of PEs / neurons
//   pe_lat     cycles from the last pe_en beat to final acc_out valid (>=1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active high
//   start      in   begin one vector (sampled only in IDLE)
//   in_data    in   input sample
//   in_valid   in   input sample valid
//   in_ready   out  sample accepted this cycle (combinational)
//   pe_rst     out  reset to all PEs (high in IDLE and CLEAR)
//   pe_bus     out  broadcast sample to all PEs
//   pe_en      out  pe_bus carries a new sample this cycle
//   pe_acc     in   concatenated PE accumulators, PE k at [k*tam +: tam]
//   out_data   out  result word
//   out_idx    out  neuron index of out_data
//   out_valid  out  out_data/out_idx valid
//   out_ready  in   downstream accepts the result
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last result is accepted
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mlp_layer_sequencer #(
    parameter int tam       = 16,
    parameter int data_size = 4,
    parameter int n_pe      = 4,
    parameter int pe_lat    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [tam-1:0]                          in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic                                    pe_rst,
    output logic [tam-1:0]                          pe_bus,
    output logic                                    pe_en,
    input  logic [n_pe*tam-1:0]                     pe_acc,
    output logic [tam-1:0]                          out_data,
    output logic [((n_pe > 1) ? $clog2(n_pe) : 1)-1:0] out_idx,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    busy,
    output logic                                    done
);

    localparam int IDX_W   = (n_pe > 1) ? $clog2(n_pe) : 1;
    // One counter serves both the STREAM beat count and the DRAIN wait,
    // so it must be wide enough for whichever of the two is longer.
    localparam int CNT_MAX = (data_size > pe_lat) ? data_size : pe_lat;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DATA_N    = CNT_W'(data_size);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(data_size - 1);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(pe_lat - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(n_pe - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        SNAP,
        OUTPUT
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [tam-1:0]   acc_buf [n_pe];
    logic             snap_en;
    logic             handshake;
    logic [IDX_W-1:0] idx_inc;

    logic [tam-1:0]   nxt_pe_bus;
    logic             nxt_pe_en;
    logic             nxt_pe_rst;
    logic [tam-1:0]   nxt_out_data;
    logic [IDX_W-1:0] nxt_out_idx;
    logic             nxt_out_valid;
    logic             nxt_busy;
    logic             nxt_done;

    // Optional activation applied on the way out; the buffer always keeps
    // the raw accumulator words.
    function automatic logic [tam-1:0] activate(input logic [tam-1:0] word);
`ifdef MLP_SEQ_RELU_EN
        activate = word[tam-1] ? {tam{1'b0}} : word;
`else
        activate = word;
`endif
    endfunction

    // The only unregistered output: samples are accepted only while
    // streaming and only until the vector is complete.
    assign in_ready  = (state == STREAM) && (cnt < DATA_N);
    assign handshake = in_valid && in_ready;
    // out_idx doubles as the result pointer while serialising.
    assign idx_inc   = out_idx + 1'b1;

    // Next-state and next-output logic. Every output except in_ready is a
    // register, so this block computes the value each one takes at the
    // next edge; anything not mentioned in a state simply holds.
    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_pe_bus    = pe_bus;
        nxt_pe_en     = 1'b0;
        nxt_out_data  = out_data;
        nxt_out_idx   = out_idx;
        nxt_out_valid = out_valid;
        nxt_done      = 1'b0;
        snap_en       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = CLEAR;
                end
            end

            CLEAR: begin
                nxt_cnt   = '0;
                nxt_state = STREAM;
            end

            STREAM: begin
                if (handshake) begin
                    nxt_pe_bus = in_data;
                    nxt_pe_en  = 1'b1;
                    if (cnt == DATA_LAST) begin
                        nxt_cnt   = '0;
                        nxt_state = DRAIN;
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (cnt == LAT_LAST) begin
                    nxt_cnt   = '0;
                    nxt_state = SNAP;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end

            SNAP: begin
                // The first result comes straight from the PE bus so it is
                // presented in the same edge that fills the buffer.
                snap_en       = 1'b1;
                nxt_out_data  = activate(pe_acc[0 +: tam]);
                nxt_out_idx   = '0;
                nxt_out_valid = 1'b1;
                nxt_state     = OUTPUT;
            end

            OUTPUT: begin
                if (out_ready) begin
                    if (out_idx == IDX_LAST) begin
                        nxt_out_valid = 1'b0;
                        nxt_out_idx   = '0;
                        nxt_done      = 1'b1;
                        nxt_state     = IDLE;
                    end else begin
                        nxt_out_idx  = idx_inc;
                        nxt_out_data = activate(acc_buf[idx_inc]);
                    end
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase

        // PEs stay in reset whenever no vector is being streamed, so stray
        // bus activity can never leak into an accumulator.
        nxt_pe_rst = (nxt_state == IDLE) || (nxt_state == CLEAR);
        nxt_busy   = (nxt_state != IDLE);
    end

    // State register and registered outputs. Reset discards any vector in
    // flight and parks the PEs in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pe_rst    <= 1'b1;
            pe_bus    <= '0;
            pe_en     <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            pe_rst    <= nxt_pe_rst;
            pe_bus    <= nxt_pe_bus;
            pe_en     <= nxt_pe_en;
            out_data  <= nxt_out_data;
            out_idx   <= nxt_out_idx;
            out_valid <= nxt_out_valid;
            busy      <= nxt_busy;
            done      <= nxt_done;
        end
    end

    // Accumulator snapshot. Taken once per vector so the PEs could in
    // principle start on the next vector while results drain out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < n_pe; k++) begin
                acc_buf[k] <= '0;
            end
        end else if (snap_en) begin
            for (int k = 0; k < n_pe; k++) begin
                acc_buf[k] <= pe_acc[k*tam +: tam];
            end
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for mlp_layer_sequencer (default parameters: tam=16,
// data_size=4, n_pe=4, pe_lat=2).
//
// A small behavioural PE model stands in for the four PEs: every PE holds
// weights {1.0, 2.0, 3.0, 4.0} and expects samples of 1.0, so its running
// sum walks 0, 1, 3, 6, 10 in FP16. The accumulators can also be forced to
// fixed per-PE words to exercise the output stage and optional ReLU.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mlp_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        pe_rst;
    logic [15:0] pe_bus;
    logic        pe_en;
    logic [63:0] pe_acc;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int checkCount = 0;
    int errorCount = 0;

    logic        forceAcc;
    logic [15:0] forceVals [4];
    logic [15:0] expData [4];

    logic [2:0]  modelCnt;
    logic        modelBad;
    logic [15:0] modelAcc;

    always #5 clk = ~clk;

    mlp_layer_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pe_rst    (pe_rst),
        .pe_bus    (pe_bus),
        .pe_en     (pe_en),
        .pe_acc    (pe_acc),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // FP16 running sum of weights 1..4 after n beats of 1.0.
    function automatic logic [15:0] partialSum(input logic [2:0] n);
        case (n)
            3'd0:    partialSum = 16'h0000;
            3'd1:    partialSum = 16'h3C00;
            3'd2:    partialSum = 16'h4200;
            3'd3:    partialSum = 16'h4600;
            3'd4:    partialSum = 16'h4900;
            default: partialSum = 16'hFFFF;
        endcase
    endfunction

    // Expected result word after the optional activation.
    function automatic logic [15:0] reluModel(input logic [15:0] w);
`ifdef MLP_SEQ_RELU_EN
        reluModel = w[15] ? 16'h0000 : w;
`else
        reluModel = w;
`endif
    endfunction

    // PE model with a two-cycle pe_en -> acc_out latency: beat count
    // registers on pe_en, accumulator registers one cycle later.
    always @(posedge clk) begin
        if (pe_rst) begin
            modelCnt <= 3'd0;
            modelBad <= 1'b0;
        end else if (pe_en) begin
            modelCnt <= modelCnt + 3'd1;
            if (pe_bus !== 16'h3C00) modelBad <= 1'b1;
        end
        modelAcc <= modelBad ? 16'hFFFF : partialSum(modelCnt);
    end

    always_comb begin
        pe_acc = {modelAcc, modelAcc, modelAcc, modelAcc};
        if (forceAcc) pe_acc = {forceVals[3], forceVals[2], forceVals[1], forceVals[0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Runs one vector of four 1.0 samples end to end and checks every cycle.
    // toggleValid: in_valid alternates; stallAtOne: out_ready low 3 cycles
    // at result 1; pulseStart: start pulsed in DRAIN and OUTPUT.
    task automatic applyStimulus(input bit toggleValid, input bit stallAtOne,
                                 input bit pulseStart, input int expCycles);
        int cycles    = 0;
        int beats     = 0;
        int accIdx    = 0;
        int stallCnt  = 0;
        int doneCount = 0;
        bit hs        = 1'b0;
        bit expInRdy;
        bit gotDone   = 1'b0;

        start     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h3C00;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("clear_busy", busy, 1);
        checkOutput("clear_pe_rst", pe_rst, 1);

        while (!gotDone && cycles < 100) begin
            in_valid  = toggleValid ? ((cycles % 2) == 0) : 1'b1;
            start     = pulseStart && (cycles == 6 || cycles == 9);
            out_ready = 1'b1;
            if (stallAtOne && accIdx == 1 && stallCnt < 3) begin
                out_ready = 1'b0;
                stallCnt++;
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_idx", out_idx, 1);
                checkOutput("stall_data", out_data, expData[1]);
            end
            expInRdy = (cycles >= 1) && (beats < 4);
            checkOutput("in_ready", in_ready, expInRdy);
            hs = in_valid && expInRdy;
            if (hs) beats++;
            if (out_valid && out_ready) begin
                checkOutput("out_idx", out_idx, accIdx);
                checkOutput("out_data", out_data, expData[accIdx]);
                accIdx++;
            end

            tick();
            cycles++;
            checkOutput("pe_en", pe_en, hs);
            if (beats > 0) checkOutput("pe_bus", pe_bus, 16'h3C00);
            if (done) begin
                doneCount++;
                gotDone = 1'b1;
            end
            checkOutput("busy", busy, !gotDone);
            checkOutput("pe_rst", pe_rst, gotDone);
        end

        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("done_seen", gotDone, 1);
        checkOutput("results", accIdx, 4);
        checkOutput("beats", beats, 4);
        if (stallAtOne) checkOutput("stall_cycles", stallCnt, 3);
        checkOutput("latency", cycles, expCycles);

        repeat (3) begin
            tick();
            if (done) doneCount++;
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_in_ready", in_ready, 0);
            checkOutput("idle_out_valid", out_valid, 0);
        end
        checkOutput("done_once", doneCount, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        forceAcc  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            forceVals[k] = 16'h0000;
            expData[k]   = 16'h4900;
        end

        // Reset state.
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pe_rst", pe_rst, 1);
        checkOutput("rst_pe_en", pe_en, 0);
        checkOutput("rst_pe_bus", pe_bus, 16'h0000);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 16'h0000);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset after two accepted beats.
        $display("[TB] reset mid-stream");
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        tick();
        checkOutput("stream_in_ready", in_ready, 1);
        tick();
        tick();
        checkOutput("beat2_pe_en", pe_en, 1);
        checkOutput("beat2_busy", busy, 1);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_pe_rst", pe_rst, 1);
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_pe_en", pe_en, 0);
        tick();
        rst = 1'b0;
        tick();

        // Clean vector with the PE model: four results of 10.0.
        $display("[TB] full-rate vector");
        applyStimulus(1'b0, 1'b0, 1'b0, 12);

        // Gapped input stream.
        $display("[TB] toggling in_valid");
        applyStimulus(1'b1, 1'b0, 1'b0, 16);

        // Output back-pressure at result 1.
        $display("[TB] out_ready stall");
        applyStimulus(1'b0, 1'b1, 1'b0, 15);

        // Stray start pulses while busy.
        $display("[TB] start while busy");
        applyStimulus(1'b0, 1'b0, 1'b1, 12);

        // Forced accumulators: negative, negative zero, positive, signed NaN.
        $display("[TB] forced accumulators");
        forceVals[0] = 16'hC900;
        forceVals[1] = 16'h8000;
        forceVals[2] = 16'h4900;
        forceVals[3] = 16'hFE00;
        for (int k = 0; k < 4; k++) expData[k] = reluModel(forceVals[k]);
        forceAcc = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        forceAcc = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
